// File: rtl/axi_slave_pkg.sv
// Shared AXI slave definitions: burst/response encodings, FSM states and helpers.
package axi_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_write_slave_mem_if.sv
// AXI4 write-channel bundle (AW, W, B) between a write master and a write slave.
interface axi_write_slave_mem_if #(
    parameter int unsigned ID_W   = 12,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic [ID_W-1:0]     s_axi_awid;
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic [7:0]          s_axi_awlen;
    logic [2:0]          s_axi_awsize;
    logic [1:0]          s_axi_awburst;
    logic                s_axi_awvalid;
    logic                s_axi_awready;

    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wlast;
    logic                s_axi_wvalid;
    logic                s_axi_wready;

    logic [ID_W-1:0]     s_axi_bid;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
        output s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready
    );

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
        input  s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
    import axi_slave_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    // Advance by one beat; WRAP keeps the upper bits and wraps inside the burst window.
    always_comb begin
        step      = ADDR_W'(1) << size;
        incr_addr = addr + step;
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        next_addr = addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_write_slave_mem.sv
// AXI4 write slave terminating one burst at a time into a byte-enabled word memory.
module axi_write_slave_mem
    import axi_slave_pkg::*;
#(
    parameter int unsigned ID_W      = 12,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    axi_write_slave_mem_if.slave         bus,
    input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]            dbg_data
);

    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned STRB_W = DATA_W / 8;

    state_e            state_q;
    logic              aw_ready_q;
    logic              w_ready_q;
    logic              b_valid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;

    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [7:0]        beat_q;
    logic              err_q;
    // Set by a bad AW; blocks every write of the burst, unlike per-beat errors.
    logic              inhibit_q;

    logic [ADDR_W-1:0] next_addr;
    logic              aw_fire;
    logic              w_fire;
    logic              aw_bad;
    logic              last_beat;
    logic              addr_oor;
    logic              beat_err;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Handshake decode, AW legality and per-beat error detection.
    always_comb begin
        aw_fire   = aw_ready_q & bus.s_axi_awvalid;
        w_fire    = w_ready_q & bus.s_axi_wvalid;
        aw_bad    = (bus.s_axi_awsize > 3'd3) ||
                    (bus.s_axi_awburst == BURST_RSVD) ||
                    ((bus.s_axi_awburst == BURST_WRAP) && !wrap_len_ok(bus.s_axi_awlen));
        last_beat = (beat_q == len_q);
        addr_oor  = (addr_q >= ADDR_W'(MEM_WORDS * 8));
        beat_err  = addr_oor || (bus.s_axi_wlast != last_beat);
        mem_we    = w_fire && !inhibit_q && !addr_oor && !rst;
        mem_idx   = addr_q[IDX_W+2:3];
    end

    // Transaction FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
            inhibit_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    aw_ready_q <= 1'b1;
                    if (aw_fire) begin
                        id_q       <= bus.s_axi_awid;
                        addr_q     <= bus.s_axi_awaddr;
                        len_q      <= bus.s_axi_awlen;
                        size_q     <= bus.s_axi_awsize;
                        burst_q    <= bus.s_axi_awburst;
                        beat_q     <= '0;
                        err_q      <= aw_bad;
                        inhibit_q  <= aw_bad;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        state_q    <= DATA;
                    end
                end
                DATA: begin
                    if (w_fire) begin
                        beat_q <= beat_q + 8'd1;
                        addr_q <= next_addr;
                        if (beat_err) begin
                            err_q <= 1'b1;
                        end
                        // Burst length is set by AWLEN alone; WLAST only feeds the error flag.
                        if (last_beat) begin
                            w_ready_q <= 1'b0;
                            b_valid_q <= 1'b1;
                            bid_q     <= id_q;
                            bresp_q   <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state_q   <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.s_axi_bready) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (bus.s_axi_wstrb[b]) begin
                    mem[mem_idx][8*b +: 8] <= bus.s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.s_axi_awready = aw_ready_q;
    assign bus.s_axi_wready  = w_ready_q;
    assign bus.s_axi_bvalid  = b_valid_q;
    assign bus.s_axi_bid     = bid_q;
    assign bus.s_axi_bresp   = bresp_q;
    assign dbg_data          = mem[dbg_addr];

endmodule

// File: tb/tb_axi_write_slave_mem.sv
// Self-checking bench for axi_write_slave_mem: B responses scoreboarded, memory via debug port.
module tb_axi_write_slave_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dbg_addr = '0;
    logic [63:0] dbg_data;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [11:0] id;
        logic [1:0]  resp;
    } b_exp_t;

    b_exp_t sb[$];

    axi_write_slave_mem_if #(.ID_W(12), .ADDR_W(32), .DATA_W(64)) bus ();

    axi_write_slave_mem #(
        .ID_W      (12),
        .ADDR_W    (32),
        .DATA_W    (64),
        .MEM_WORDS (256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (got hang, want completion)");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the AW handshake.
    task automatic drive_aw(input logic [11:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int cnt = 0;
        bus.s_axi_awid    = id;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awlen   = len;
        bus.s_axi_awsize  = size;
        bus.s_axi_awburst = burst;
        bus.s_axi_awvalid = 1'b1;
        while (!bus.s_axi_awready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) begin
            tests++;
            fails++;
            $display("FAIL aw_timeout: awready got 0, want 1 within 50 cycles");
        end
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
    endtask

    // Called at a negedge; leaves wvalid high and returns at the negedge after the handshake.
    task automatic drive_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int cnt = 0;
        bus.s_axi_wdata  = data;
        bus.s_axi_wstrb  = strb;
        bus.s_axi_wlast  = last;
        bus.s_axi_wvalid = 1'b1;
        while (!bus.s_axi_wready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) begin
            tests++;
            fails++;
            $display("FAIL w_timeout: wready got 0, want 1 within 50 cycles");
        end
        @(negedge clk);
    endtask

    // Collects one B response and the scoreboard entry it is to be compared against.
    task automatic collect_b(output logic [11:0] oid, output logic [1:0] oresp,
                             output logic [11:0] eid, output logic [1:0] eresp);
        int cnt = 0;
        b_exp_t e;
        bus.s_axi_bready = 1'b1;
        while (!bus.s_axi_bvalid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        oid   = bus.s_axi_bid;
        oresp = bus.s_axi_bresp;
        if (cnt >= 50) begin
            tests++;
            fails++;
            $display("FAIL b_timeout: bvalid got 0, want 1 within 50 cycles");
            oresp = 2'bxx;
        end
        if (sb.size() == 0) begin
            eid   = 12'hxxx;
            eresp = 2'bxx;
        end else begin
            e     = sb.pop_front();
            eid   = e.id;
            eresp = e.resp;
        end
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.s_axi_awready !== 1'b0 || bus.s_axi_wready !== 1'b0 || bus.s_axi_bvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: aw/w/b got %b%b%b, want 000",
                     bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid);
        end
        tests++;
        if (bus.s_axi_bid !== 12'h0 || bus.s_axi_bresp !== 2'b00) begin
            fails++;
            $display("FAIL reset_b: bid/bresp got %h/%b, want 000/00", bus.s_axi_bid, bus.s_axi_bresp);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.s_axi_awready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: awready got %b, want 1", bus.s_axi_awready);
        end
    endtask

    task automatic test_single();
        logic [11:0] oid, eid;
        logic [1:0]  oresp, eresp;
        drive_aw(12'hABC, 32'h10, 8'd0, 3'd3, 2'b01);
        sb.push_back('{id: 12'hABC, resp: 2'b00});
        drive_w(64'h1122334455667788, 8'hFF, 1'b1);
        bus.s_axi_wvalid = 1'b0;
        collect_b(oid, oresp, eid, eresp);
        tests++;
        if (oid !== eid || oresp !== eresp) begin
            fails++;
            $display("FAIL single_b: got id %h resp %b, want id %h resp %b", oid, oresp, eid, eresp);
        end
        dbg_addr = 8'd2;
        #1;
        tests++;
        if (dbg_data !== 64'h1122334455667788) begin
            fails++;
            $display("FAIL single_mem: mem[2] got %h, want 1122334455667788", dbg_data);
        end
    endtask

    task automatic test_incr();
        logic [11:0] oid, eid;
        logic [1:0]  oresp, eresp;
        drive_aw(12'h001, 32'h0, 8'd3, 3'd3, 2'b01);
        sb.push_back('{id: 12'h001, resp: 2'b00});
        for (int i = 1; i <= 4; i++) begin
            drive_w(64'(i), 8'hFF, (i == 4));
        end
        bus.s_axi_wvalid = 1'b0;
        tests++;
        if (bus.s_axi_bvalid !== 1'b1 || bus.s_axi_wready !== 1'b0) begin
            fails++;
            $display("FAIL incr_bvalid_timing: bvalid/wready got %b/%b, want 1/0",
                     bus.s_axi_bvalid, bus.s_axi_wready);
        end
        collect_b(oid, oresp, eid, eresp);
        tests++;
        if (oid !== eid || oresp !== eresp) begin
            fails++;
            $display("FAIL incr_b: got id %h resp %b, want id %h resp %b", oid, oresp, eid, eresp);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 8'(i);
            #1;
            tests++;
            if (dbg_data !== 64'(i + 1)) begin
                fails++;
                $display("FAIL incr_mem: mem[%0d] got %h, want %h", i, dbg_data, 64'(i + 1));
            end
        end
    endtask

    task automatic test_wrap();
        logic [11:0] oid, eid;
        logic [1:0]  oresp, eresp;
        logic [63:0] vals [4];
        logic [7:0]  idx [4];
        vals[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        vals[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        vals[2] = 64'hCCCC_CCCC_CCCC_CCCC;
        vals[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        idx[0] = 8'd3;
        idx[1] = 8'd0;
        idx[2] = 8'd1;
        idx[3] = 8'd2;
        drive_aw(12'h002, 32'h18, 8'd3, 3'd3, 2'b10);
        sb.push_back('{id: 12'h002, resp: 2'b00});
        for (int i = 0; i < 4; i++) begin
            drive_w(vals[i], 8'hFF, (i == 3));
        end
        bus.s_axi_wvalid = 1'b0;
        collect_b(oid, oresp, eid, eresp);
        tests++;
        if (oid !== eid || oresp !== eresp) begin
            fails++;
            $display("FAIL wrap_b: got id %h resp %b, want id %h resp %b", oid, oresp, eid, eresp);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = idx[i];
            #1;
            tests++;
            if (dbg_data !== vals[i]) begin
                fails++;
                $display("FAIL wrap_mem: mem[%0d] got %h, want %h", idx[i], dbg_data, vals[i]);
            end
        end
    endtask

    task automatic test_strobe();
        logic [11:0] oid, eid;
        logic [1:0]  oresp, eresp;
        drive_aw(12'h003, 32'h28, 8'd0, 3'd3, 2'b01);
        sb.push_back('{id: 12'h003, resp: 2'b00});
        drive_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        bus.s_axi_wvalid = 1'b0;
        collect_b(oid, oresp, eid, eresp);
        drive_aw(12'h004, 32'h28, 8'd0, 3'd3, 2'b01);
        sb.push_back('{id: 12'h004, resp: 2'b00});
        drive_w(64'h0, 8'h0F, 1'b1);
        bus.s_axi_wvalid = 1'b0;
        collect_b(oid, oresp, eid, eresp);
        tests++;
        if (oid !== eid || oresp !== eresp) begin
            fails++;
            $display("FAIL strobe_b: got id %h resp %b, want id %h resp %b", oid, oresp, eid, eresp);
        end
        dbg_addr = 8'd5;
        #1;
        tests++;
        if (dbg_data !== 64'hFFFF_FFFF_0000_0000) begin
            fails++;
            $display("FAIL strobe_mem: mem[5] got %h, want ffffffff00000000", dbg_data);
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] oid, eid;
        logic [1:0]  oresp, eresp;
        b_exp_t e;
        drive_aw(12'h321, 32'h40, 8'd0, 3'd3, 2'b01);
        sb.push_back('{id: 12'h321, resp: 2'b00});
        drive_w(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        bus.s_axi_wvalid  = 1'b0;
        // Second AW is presented while B is stalled.
        bus.s_axi_awid    = 12'h654;
        bus.s_axi_awaddr  = 32'h48;
        bus.s_axi_awlen   = 8'd0;
        bus.s_axi_awsize  = 3'd3;
        bus.s_axi_awburst = 2'b01;
        bus.s_axi_awvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (bus.s_axi_bvalid !== 1'b1 || bus.s_axi_bid !== 12'h321 ||
                bus.s_axi_bresp !== 2'b00 || bus.s_axi_awready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold: cycle %0d bvalid/bid/bresp/awready got %b/%h/%b/%b, want 1/321/00/0",
                         c, bus.s_axi_bvalid, bus.s_axi_bid, bus.s_axi_bresp, bus.s_axi_awready);
            end
            @(negedge clk);
        end
        bus.s_axi_bready = 1'b1;
        e = sb.pop_front();
        tests++;
        if (bus.s_axi_bid !== e.id || bus.s_axi_bresp !== e.resp) begin
            fails++;
            $display("FAIL bp_b: got id %h resp %b, want id %h resp %b",
                     bus.s_axi_bid, bus.s_axi_bresp, e.id, e.resp);
        end
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
        tests++;
        if (bus.s_axi_bvalid !== 1'b0 || bus.s_axi_awready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: bvalid/awready got %b/%b, want 0/1",
                     bus.s_axi_bvalid, bus.s_axi_awready);
        end
        sb.push_back('{id: 12'h654, resp: 2'b00});
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
        tests++;
        if (bus.s_axi_awready !== 1'b0 || bus.s_axi_wready !== 1'b1) begin
            fails++;
            $display("FAIL bp_accept: awready/wready got %b/%b, want 0/1",
                     bus.s_axi_awready, bus.s_axi_wready);
        end
        drive_w(64'h5555_6666_7777_8888, 8'hFF, 1'b1);
        bus.s_axi_wvalid = 1'b0;
        collect_b(oid, oresp, eid, eresp);
        tests++;
        if (oid !== eid || oresp !== eresp) begin
            fails++;
            $display("FAIL bp_second_b: got id %h resp %b, want id %h resp %b", oid, oresp, eid, eresp);
        end
        dbg_addr = 8'd9;
        #1;
        tests++;
        if (dbg_data !== 64'h5555_6666_7777_8888) begin
            fails++;
            $display("FAIL bp_mem: mem[9] got %h, want 5555666677778888", dbg_data);
        end
    endtask

    task automatic test_errors();
        logic [11:0] oid, eid;
        logic [1:0]  oresp, eresp;
        // Out of range: index bits of 0x800 alias mem[0], which must keep the WRAP value.
        drive_aw(12'h0E1, 32'h800, 8'd0, 3'd3, 2'b01);
        sb.push_back('{id: 12'h0E1, resp: 2'b10});
        drive_w(64'h1234_1234_1234_1234, 8'hFF, 1'b1);
        bus.s_axi_wvalid = 1'b0;
        collect_b(oid, oresp, eid, eresp);
        tests++;
        if (oid !== eid || oresp !== eresp) begin
            fails++;
            $display("FAIL oor_b: got id %h resp %b, want id %h resp %b", oid, oresp, eid, eresp);
        end
        dbg_addr = 8'd0;
        #1;
        tests++;
        if (dbg_data !== 64'hBBBB_BBBB_BBBB_BBBB) begin
            fails++;
            $display("FAIL oor_mem: mem[0] got %h, want bbbbbbbbbbbbbbbb", dbg_data);
        end

        // Early wlast: all four beats still accepted, written, and flagged.
        drive_aw(12'h0E2, 32'h60, 8'd3, 3'd3, 2'b01);
        sb.push_back('{id: 12'h0E2, resp: 2'b10});
        for (int i = 0; i < 4; i++) begin
            drive_w(64'h100 + 64'(i), 8'hFF, (i == 1));
        end
        bus.s_axi_wvalid = 1'b0;
        tests++;
        if (bus.s_axi_bvalid !== 1'b1) begin
            fails++;
            $display("FAIL wlast_len: bvalid after 4 beats got %b, want 1", bus.s_axi_bvalid);
        end
        collect_b(oid, oresp, eid, eresp);
        tests++;
        if (oid !== eid || oresp !== eresp) begin
            fails++;
            $display("FAIL wlast_b: got id %h resp %b, want id %h resp %b", oid, oresp, eid, eresp);
        end
        dbg_addr = 8'd15;
        #1;
        tests++;
        if (dbg_data !== 64'h103) begin
            fails++;
            $display("FAIL wlast_mem: mem[15] got %h, want 0000000000000103", dbg_data);
        end

        // Reserved burst: preload mem[16], then a two-beat burst 11 must not touch it.
        drive_aw(12'h0E3, 32'h80, 8'd0, 3'd3, 2'b01);
        sb.push_back('{id: 12'h0E3, resp: 2'b00});
        drive_w(64'hCAFE_F00D_CAFE_F00D, 8'hFF, 1'b1);
        bus.s_axi_wvalid = 1'b0;
        collect_b(oid, oresp, eid, eresp);
        drive_aw(12'h0E4, 32'h80, 8'd1, 3'd3, 2'b11);
        sb.push_back('{id: 12'h0E4, resp: 2'b10});
        drive_w(64'h0, 8'hFF, 1'b0);
        drive_w(64'h0, 8'hFF, 1'b1);
        bus.s_axi_wvalid = 1'b0;
        collect_b(oid, oresp, eid, eresp);
        tests++;
        if (oid !== eid || oresp !== eresp) begin
            fails++;
            $display("FAIL rsvd_b: got id %h resp %b, want id %h resp %b", oid, oresp, eid, eresp);
        end
        dbg_addr = 8'd16;
        #1;
        tests++;
        if (dbg_data !== 64'hCAFE_F00D_CAFE_F00D) begin
            fails++;
            $display("FAIL rsvd_mem: mem[16] got %h, want cafef00dcafef00d", dbg_data);
        end
    endtask

    task automatic test_reset_mid();
        int bseen = 0;
        drive_aw(12'h077, 32'h88, 8'd3, 3'd3, 2'b01);
        drive_w(64'h7777_0000_7777_0000, 8'hFF, 1'b0);
        bus.s_axi_wvalid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.s_axi_awready !== 1'b1 || bus.s_axi_wready !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_ready: awready/wready got %b/%b, want 1/0",
                     bus.s_axi_awready, bus.s_axi_wready);
        end
        bus.s_axi_bready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (bus.s_axi_bvalid === 1'b1) bseen++;
            @(negedge clk);
        end
        bus.s_axi_bready = 1'b0;
        tests++;
        if (bseen != 0) begin
            fails++;
            $display("FAIL rstmid_nob: bvalid cycles got %0d, want 0", bseen);
        end
        dbg_addr = 8'd17;
        #1;
        tests++;
        if (dbg_data !== 64'h7777_0000_7777_0000) begin
            fails++;
            $display("FAIL rstmid_mem: mem[17] got %h, want 7777000077770000", dbg_data);
        end
    endtask

    initial begin
        bus.s_axi_awid    = '0;
        bus.s_axi_awaddr  = '0;
        bus.s_axi_awlen   = '0;
        bus.s_axi_awsize  = '0;
        bus.s_axi_awburst = '0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata   = '0;
        bus.s_axi_wstrb   = '0;
        bus.s_axi_wlast   = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b0;

        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_strobe();
        test_backpressure();
        test_errors();
        test_reset_mid();

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: pending responses got %0d, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
